// File: rtl/fifo_synch_1r1w_flex.sv
// Synchronous single-read/single-write FIFO with first-word fall-through.
// The head word is held in a register so data_o never comes straight from
// the memory array. Depth need not be a power of two: the pointers wrap
// explicitly at depth_p-1. Almost-full/empty flags are thresholded at run time.
module fifo_synch_1r1w_flex #(
    parameter  int width_p = 8,
    parameter  int depth_p = 16,
    localparam int cnt_w   = $clog2(depth_p + 1),
    localparam int ptr_w   = $clog2(depth_p)
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               flush_i,
    input  logic [width_p-1:0] data_i,
    input  logic               valid_i,
    output logic               ready_o,
    output logic               valid_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i,
    input  logic [cnt_w-1:0]   afull_thresh_i,
    input  logic [cnt_w-1:0]   aempty_thresh_i,
    output logic [cnt_w-1:0]   count_o,
    output logic               almost_full_o,
    output logic               almost_empty_o,
    output logic               underflow_o
);

    localparam logic [ptr_w-1:0] ptr_max = ptr_w'(depth_p - 1);
    localparam logic [cnt_w-1:0] cnt_max = cnt_w'(depth_p);

    logic [width_p-1:0] mem_q [depth_p];

    logic [ptr_w-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ptr_w-1:0]   rd_ptr_q, rd_ptr_d;
    logic [cnt_w-1:0]   count_q, count_d;
    logic [width_p-1:0] data_q, data_d;
    logic               underflow_q, underflow_d;

    logic               enq;
    logic               deq;
    logic               mem_we;
    logic [ptr_w-1:0]   wr_ptr_inc;
    logic [ptr_w-1:0]   rd_ptr_inc;

    assign ready_o        = (count_q != cnt_max);
    assign valid_o        = (count_q != '0);
    assign data_o         = data_q;
    assign count_o        = count_q;
    assign underflow_o    = underflow_q;
    assign almost_full_o  = (count_q >= afull_thresh_i);
    assign almost_empty_o = (count_q <= aempty_thresh_i);

    // Next-state: handshakes, pointer wrap, occupancy and head-register source.
    always_comb begin
        enq         = valid_i & ready_o;
        deq         = yumi_i & valid_o;
        mem_we      = enq & ~flush_i;
        wr_ptr_inc  = (wr_ptr_q == ptr_max) ? '0 : wr_ptr_q + ptr_w'(1);
        rd_ptr_inc  = (rd_ptr_q == ptr_max) ? '0 : rd_ptr_q + ptr_w'(1);

        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        data_d      = data_q;
        underflow_d = underflow_q;

        if (flush_i) begin
            // Flush wins over any handshake; the head register is left alone.
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            underflow_d = 1'b0;
        end else begin
            underflow_d = underflow_q | (yumi_i & ~valid_o);
            if (enq) wr_ptr_d = wr_ptr_inc;
            if (deq) rd_ptr_d = rd_ptr_inc;

            unique case ({enq, deq})
                2'b10:   count_d = count_q + cnt_w'(1);
                2'b01:   count_d = count_q - cnt_w'(1);
                default: count_d = count_q;
            endcase

            // The entry after the read pointer already holds the next word when
            // two or more are stored; with exactly one stored, the incoming word
            // is the next head and never passes through memory on its way out.
            if (deq && (count_q >= cnt_w'(2))) begin
                data_d = mem_q[rd_ptr_inc];
            end else if (enq && deq && (count_q == cnt_w'(1))) begin
                data_d = data_i;
            end else if (enq && (count_q == '0)) begin
                data_d = data_i;
            end
        end
    end

    // Storage array; deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Control and head-register flops with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            data_q      <= '0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            data_q      <= data_d;
            underflow_q <= underflow_d;
        end
    end

endmodule

// File: tb/tb_fifo_synch_1r1w_flex.sv
// Bench for fifo_synch_1r1w_flex at depth 5. A queue-based reference model is
// advanced by the driver; dequeued words go to a scoreboard queue that an
// independent negedge monitor pops whenever the DUT shows a dequeue.
module tb_fifo_synch_1r1w_flex;

    localparam int W  = 8;
    localparam int D  = 5;
    localparam int CW = $clog2(D + 1);

    logic          clk_i;
    logic          reset_n_i;
    logic          flush_i;
    logic [W-1:0]  data_i;
    logic          valid_i;
    logic          ready_o;
    logic          valid_o;
    logic [W-1:0]  data_o;
    logic          yumi_i;
    logic [CW-1:0] afull_thresh_i;
    logic [CW-1:0] aempty_thresh_i;
    logic [CW-1:0] count_o;
    logic          almost_full_o;
    logic          almost_empty_o;
    logic          underflow_o;

    fifo_synch_1r1w_flex #(.width_p(W), .depth_p(D)) dut (
        .clk_i           (clk_i),
        .reset_n_i       (reset_n_i),
        .flush_i         (flush_i),
        .data_i          (data_i),
        .valid_i         (valid_i),
        .ready_o         (ready_o),
        .valid_o         (valid_o),
        .data_o          (data_o),
        .yumi_i          (yumi_i),
        .afull_thresh_i  (afull_thresh_i),
        .aempty_thresh_i (aempty_thresh_i),
        .count_o         (count_o),
        .almost_full_o   (almost_full_o),
        .almost_empty_o  (almost_empty_o),
        .underflow_o     (underflow_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int          n_vec = 0;
    int          n_err = 0;

    logic [W-1:0] mq[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] disp;
    logic [W-1:0] s_disp;
    int           s_cnt;
    bit           uf;
    bit           s_uf;
    bit           mon_en;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus: snapshot the model as the DUT should now look,
    // drive the inputs, then advance the model across the coming edge.
    task automatic step(input bit v, input logic [W-1:0] d, input bit y, input bit f,
                        output bit acc);
        bit do_enq;
        bit do_deq;
        @(posedge clk_i);
        #1;
        s_cnt = mq.size();
        if (s_cnt > 0) disp = mq[0];
        s_disp = disp;
        s_uf   = uf;
        mon_en = 1'b1;

        valid_i = v;
        data_i  = d;
        yumi_i  = y;
        flush_i = f;

        acc = 1'b0;
        if (f) begin
            mq.delete();
            uf = 1'b0;
        end else begin
            do_enq = v && (mq.size() < D);
            do_deq = y && (mq.size() > 0);
            if (y && mq.size() == 0) uf = 1'b1;
            if (do_deq) exp_q.push_back(mq.pop_front());
            if (do_enq) mq.push_back(d);
            acc = do_enq;
        end
    endtask

    task automatic idle();
        bit a;
        step(1'b0, '0, 1'b0, 1'b0, a);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_count"}, 32'(count_o), 32'd0);
        chk({tag, "_valid"}, 32'(valid_o), 32'd0);
        chk({tag, "_ready"}, 32'(ready_o), 32'd1);
        chk({tag, "_data"},  32'(data_o),  32'd0);
        chk({tag, "_uflow"}, 32'(underflow_o), 32'd0);
        chk({tag, "_aempty"}, 32'(almost_empty_o), 32'd1);
        chk({tag, "_afull"}, 32'(almost_full_o), 32'(afull_thresh_i == '0));
    endtask

    // Monitor: compare status against the snapshot and pop the scoreboard on each dequeue.
    always @(negedge clk_i) begin
        if (mon_en && reset_n_i) begin
            chk("count",  32'(count_o),        32'(s_cnt));
            chk("valid",  32'(valid_o),        32'(s_cnt != 0));
            chk("ready",  32'(ready_o),        32'(s_cnt != D));
            chk("afull",  32'(almost_full_o),  32'(s_cnt >= int'(afull_thresh_i)));
            chk("aempty", 32'(almost_empty_o), 32'(s_cnt <= int'(aempty_thresh_i)));
            chk("uflow",  32'(underflow_o),    32'(s_uf));
            chk("head",   32'(data_o),         32'(s_disp));
            if (valid_o && yumi_i && !flush_i) begin
                if (exp_q.size() == 0) begin
                    chk("deq_unexpected", 32'd1, 32'd0);
                end else begin
                    chk("deq_data", 32'(data_o), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        bit a;
        int sent;
        int guard;

        mon_en          = 1'b0;
        disp            = '0;
        uf              = 1'b0;
        reset_n_i       = 1'b0;
        flush_i         = 1'b0;
        valid_i         = 1'b0;
        yumi_i          = 1'b0;
        data_i          = '0;
        afull_thresh_i  = CW'(4);
        aempty_thresh_i = CW'(1);

        #2;
        check_reset_outputs("por");
        #11;
        reset_n_i = 1'b1;

        // Fill to full, then offer a sixth word that must be refused.
        // Thresholds afull=4 / aempty=1 are checked at every count on the way.
        for (int i = 1; i <= 5; i++) step(1'b1, W'(i), 1'b0, 1'b0, a);
        step(1'b1, 8'h06, 1'b0, 1'b0, a);
        chk("sixth_refused", 32'(a), 32'd0);
        idle();
        while (mq.size() > 0) step(1'b0, '0, 1'b1, 1'b0, a);
        idle();

        // Wrap-around: twelve words through with random consumer pacing.
        sent  = 0;
        guard = 0;
        while ((sent < 12 || mq.size() > 0) && guard < 200) begin
            step(sent < 12, W'(8'h10 + sent), 1'($urandom_range(0, 1)), 1'b0, a);
            if (a) sent++;
            guard++;
        end
        chk("wrap_done", 32'(guard < 200), 32'd1);
        idle();

        // Bypass: one word held, enqueue and dequeue together.
        step(1'b1, 8'hAA, 1'b0, 1'b0, a);
        step(1'b1, 8'hBB, 1'b1, 1'b0, a);
        idle();
        step(1'b0, '0, 1'b1, 1'b0, a);
        idle();

        // Flush with a same-cycle enqueue: count 3 -> 0, head unchanged.
        for (int i = 0; i < 3; i++) step(1'b1, W'(8'h30 + i), 1'b0, 1'b0, a);
        step(1'b1, 8'h99, 1'b0, 1'b1, a);
        idle();

        // Underflow: yumi while empty is sticky and changes nothing else.
        step(1'b0, '0, 1'b1, 1'b0, a);
        idle();
        step(1'b1, 8'h44, 1'b0, 1'b0, a);
        step(1'b0, '0, 1'b1, 1'b0, a);
        idle();
        step(1'b0, '0, 1'b0, 1'b1, a);
        idle();

        // Asynchronous reset in the middle of a fill.
        step(1'b1, 8'h51, 1'b0, 1'b0, a);
        step(1'b1, 8'h52, 1'b1, 1'b0, a);
        step(1'b1, 8'h53, 1'b0, 1'b0, a);
        @(posedge clk_i);
        #3;
        reset_n_i = 1'b0;
        mon_en    = 1'b0;
        #1;
        check_reset_outputs("midrst");
        valid_i = 1'b0;
        yumi_i  = 1'b0;
        flush_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #3;
        check_reset_outputs("midrst_hold");
        mq.delete();
        exp_q.delete();
        disp      = '0;
        uf        = 1'b0;
        reset_n_i = 1'b1;
        step(1'b1, 8'h61, 1'b0, 1'b0, a);
        idle();

        // Random traffic, including out-of-range thresholds and occasional flush.
        for (int i = 0; i < 400; i++) begin
            if ((i % 37) == 0) begin
                afull_thresh_i  = CW'($urandom_range(0, 7));
                aempty_thresh_i = CW'($urandom_range(0, 7));
            end
            step(1'($urandom_range(0, 1)), W'($urandom_range(0, 255)),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 40) == 0), a);
        end

        guard = 0;
        while (mq.size() > 0 && guard < 20) begin
            step(1'b0, '0, 1'b1, 1'b0, a);
            guard++;
        end
        idle();
        @(negedge clk_i);
        #1;
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_synch_1r1w_flex.md
FIFO_SYNCH_1R1W_FLEX -- requirements
Module: fifo_synch_1r1w_flex

Interface
REQ-001 SHALL have parameter width_p, default 8, which sets the word width in bits.
REQ-002 SHALL have parameter depth_p, default 16, which sets the capacity in words; any integer >= 2 is legal, and a power of two is not required.
REQ-003 SHALL derive cnt_w = $clog2(depth_p+1) as the width of the occupancy and threshold ports.
REQ-004 SHALL have port clk_i, input, width 1: clock, with all state updated on its rising edge.
REQ-005 SHALL have port reset_n_i, input, width 1: reset, asynchronous, active-low.
REQ-006 SHALL have port flush_i, input, width 1: synchronous discard of all stored words.
REQ-007 SHALL have port data_i, input, width width_p: enqueue data.
REQ-008 SHALL have port valid_i, input, width 1: producer offers data_i.
REQ-009 SHALL have port ready_o, output, width 1: FIFO can accept a word this cycle.
REQ-010 SHALL have port valid_o, output, width 1: data_o holds the oldest stored word.
REQ-011 SHALL have port data_o, output, width width_p: head word, driven from a register.
REQ-012 SHALL have port yumi_i, input, width 1: consumer takes the head word this cycle.
REQ-013 SHALL have port afull_thresh_i, input, width cnt_w: almost-full threshold.
REQ-014 SHALL have port aempty_thresh_i, input, width cnt_w: almost-empty threshold.
REQ-015 SHALL have port count_o, output, width cnt_w: number of stored words.
REQ-016 SHALL have port almost_full_o, output, width 1: count_o >= afull_thresh_i.
REQ-017 SHALL have port almost_empty_o, output, width 1: count_o <= aempty_thresh_i.
REQ-018 SHALL have port underflow_o, output, width 1: sticky flag recording a yumi_i asserted while valid_o was low.

Function
REQ-019 SHALL define enqueue = valid_i & ready_o and dequeue = yumi_i & valid_o.
REQ-020 SHALL drive ready_o = (count_o != depth_p) and valid_o = (count_o != 0).
REQ-021 SHALL make ready_o independent of yumi_i: when full, a same-cycle dequeue does not allow an enqueue in that cycle.
REQ-022 SHALL store words in a depth_p-entry memory addressed by read/write pointers of width $clog2(depth_p).
REQ-023 SHALL wrap each pointer from depth_p-1 to 0 when it advances; pointers are never assumed to wrap naturally.
REQ-024 SHALL track occupancy in a count register: +1 on enqueue only, -1 on dequeue only, unchanged on both or neither.
REQ-025 SHALL operate first-word fall-through: a word enqueued into an empty FIFO appears on data_o with valid_o=1 on the next cycle.
REQ-026 SHALL, on a dequeue with count_o >= 2, load data_o from the memory entry after the read pointer, accounting for wrap.
REQ-027 SHALL, on a simultaneous enqueue and dequeue with count_o == 1, load data_o directly from data_i (bypass).
REQ-028 SHALL, on an enqueue alone with count_o == 0, load data_o from data_i; otherwise an enqueue alone leaves data_o unchanged.
REQ-029 SHALL hold data_o at its last value while valid_o=0.
REQ-030 SHALL keep the word on data_o stable while valid_o=1 and yumi_i=0.
REQ-031 SHALL give flush_i priority over enqueue and dequeue: pointers and count go to 0, same-cycle data_i is dropped, and underflow_o clears.
REQ-032 SHALL NOT change data_o on flush.
REQ-033 SHALL set underflow_o on any cycle with yumi_i=1 and valid_o=0, and hold it until flush or reset.
REQ-034 SHALL leave FIFO state unchanged on a yumi_i asserted while empty.
REQ-035 SHALL decode almost_full_o and almost_empty_o combinationally from the count register and the threshold inputs; threshold changes take effect in the same cycle.
REQ-036 SHALL allow threshold values above depth_p without error: afull never asserts and aempty always asserts.

Reset
REQ-037 SHALL, while reset_n_i=0, asynchronously force pointers, count_o, data_o and underflow_o to 0.
REQ-038 SHALL therefore show during reset ready_o=1, valid_o=0, and almost_full_o and almost_empty_o per REQ-035 with count 0.
REQ-039 SHALL NOT reset memory contents.
REQ-040 SHALL discard all stored words on a reset asserted mid-operation; the first enqueue after release behaves as into an empty FIFO.

Verification
REQ-041 SHALL cover fill to full: depth_p=5, enqueue 0x01..0x05 with yumi_i=0 -> count_o=5, ready_o=0, and a 6th valid_i is not accepted.
REQ-042 SHALL cover wrap-around: depth_p=5, enqueue/dequeue 12 words 0x10..0x1B with random yumi_i -> words leave in order with none lost or duplicated.
REQ-043 SHALL cover the bypass case: count_o=1 holding 0xAA, enqueue 0xBB with yumi_i=1 -> next cycle data_o=0xBB, count_o=1.
REQ-044 SHALL cover thresholds: afull=4 and aempty=1, step count 0->5 -> almost_empty_o=1 at counts 0-1 and almost_full_o=1 at counts >= 4.
REQ-045 SHALL cover flush with enqueue: count_o=3, flush_i=1 with valid_i=1 -> next cycle count_o=0, valid_o=0, and data_o unchanged.
REQ-046 SHALL cover underflow and reset: yumi_i=1 while empty -> underflow_o=1 sticky and count stays 0; reset_n_i pulse mid-fill -> all outputs reach their reset values asynchronously.
